// File: rtl/shift_pkg.sv
// Shared widths, latency default and FSM encoding for the shift arbiter.
package shift_pkg;
  localparam int OP_W          = 3;
  localparam int NUM_W         = 8;
  localparam int DATA_W        = 32;
  localparam int CNT_W         = 4;
  localparam int SHIFT_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational; a tie goes to the requester not in last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);
  assign any = |req;

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end
endmodule

// File: rtl/shift_arbiter.sv
// Shares one external shifter between two requesters; result captured SHIFT_LAT edges after acceptance.
// One command in flight: requesters see no ready until the owner has consumed its response.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int SHIFT_LAT = SHIFT_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [NUM_W-1:0]  req0_num,
  input  logic [NUM_W-1:0]  req1_num,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req0_setc,
  input  logic              req1_setc,
  output logic              resp0_valid,
  output logic              resp1_valid,
  input  logic              resp0_ready,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_carry,
  output logic [OP_W-1:0]   sh_op,
  output logic [NUM_W-1:0]  sh_num,
  output logic [DATA_W-1:0] sh_data,
  output logic              sh_carry_in,
  input  logic [DATA_W-1:0] sh_out,
  input  logic              sh_carry_out,
  output logic              carry_flag
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              setc_q, setc_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_carry_q, resp_carry_d;
  logic              carry_flag_q, carry_flag_d;
  logic              grant, any;

  rr_arb2 u_arb (
    .req   ({req1_valid, req0_valid}),
    .last  (last_grant_q),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    num_d        = num_q;
    data_d       = data_q;
    setc_d       = setc_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    resp_data_d  = resp_data_q;
    resp_carry_d = resp_carry_q;
    carry_flag_d = carry_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d      = ST_BUSY;
          cnt_d        = CNT_W'(SHIFT_LAT);
          op_d         = grant ? req1_op   : req0_op;
          num_d        = grant ? req1_num  : req0_num;
          data_d       = grant ? req1_data : req0_data;
          setc_d       = grant ? req1_setc : req0_setc;
          owner_d      = grant;
          last_grant_d = grant;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d      = ST_RESP;
          cnt_d        = '0;
          resp_data_d  = sh_out;
          resp_carry_d = sh_carry_out;
          if (setc_q) carry_flag_d = sh_carry_out;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (owner_q ? resp1_ready : resp0_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      num_q        <= '0;
      data_q       <= '0;
      setc_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      resp_data_q  <= '0;
      resp_carry_q <= 1'b0;
      carry_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      num_q        <= num_d;
      data_q       <= data_d;
      setc_q       <= setc_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      resp_data_q  <= resp_data_d;
      resp_carry_q <= resp_carry_d;
      carry_flag_q <= carry_flag_d;
    end
  end

  assign req0_ready  = !rst && (state_q == ST_IDLE) && any && !grant;
  assign req1_ready  = !rst && (state_q == ST_IDLE) && any && grant;
  assign resp0_valid = (state_q == ST_RESP) && !owner_q;
  assign resp1_valid = (state_q == ST_RESP) && owner_q;
  assign resp_data   = resp_data_q;
  assign resp_carry  = resp_carry_q;
  assign sh_op       = op_q;
  assign sh_num      = num_q;
  assign sh_data     = data_q;
  assign sh_carry_in = carry_flag_q;
  assign carry_flag  = carry_flag_q;
endmodule
